// File: rtl/systolic_feed_scheduler_pkg.sv
// Shared types and default sizing for the systolic feed scheduler.
package systolic_feed_scheduler_pkg;

  localparam int unsigned LANES_DEF    = 5;
  localparam int unsigned LEN_W_DEF    = 7;
  localparam int unsigned PIPE_LAT_DEF = 10;
  localparam int unsigned STALL_W_DEF  = 16;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FILL,
    STREAM,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/systolic_feed_scheduler_skew_lane_decoder.sv
// Combinational skew decoder: lane i is due while i <= cyc < i + len.
module skew_lane_decoder #(
  parameter int unsigned LANES = 5,
  parameter int unsigned LEN_W = 7,
  parameter int unsigned CYC_W = LEN_W + 3
) (
  input  logic [CYC_W-1:0] cyc,
  input  logic [LEN_W-1:0] len,
  output logic [LANES-1:0] due
);

  // Per-lane window compare against the shared wavefront counter
  always_comb begin
    due = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      due[i] = (cyc >= CYC_W'(i)) && (cyc < (CYC_W'(i) + CYC_W'(len)));
    end
  end

endmodule

// File: rtl/systolic_feed_scheduler.sv
// Sequences skewed reads from the operand FIFOs into the systolic array.
module systolic_feed_scheduler
  import systolic_feed_scheduler_pkg::*;
#(
  parameter int unsigned LANES    = LANES_DEF,
  parameter int unsigned LEN_W    = LEN_W_DEF,
  parameter int unsigned PIPE_LAT = PIPE_LAT_DEF,
  parameter int unsigned STALL_W  = STALL_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [LEN_W-1:0]   burst_len,
  input  logic               fill_done,
  input  logic               abort,
  input  logic [LANES-1:0]   buf_empty,
  output logic [LANES-1:0]   rd_en,
  output logic [LANES-1:0]   lane_valid,
  output logic               array_clr,
  output logic               busy,
  output logic               done,
  output logic               len_err,
  output logic [STALL_W-1:0] stall_cycles
);

  localparam int unsigned CYC_W = LEN_W + 3;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic               fill_seen_q, fill_seen_d;
  logic [STALL_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [LANES-1:0]   rd_en_q, rd_en_d;
  logic [LANES-1:0]   lane_valid_q, lane_valid_d;
  logic               array_clr_q, array_clr_d;
  logic               len_err_q, len_err_d;

  logic [LANES-1:0]   due;
  logic               stall;
  logic               wait_go;
  logic               last_rd;
  logic               drain_end;

  skew_lane_decoder #(
    .LANES (LANES),
    .LEN_W (LEN_W),
    .CYC_W (CYC_W)
  ) u_skew_lane_decoder (
    .cyc (cyc_q),
    .len (len_q),
    .due (due)
  );

  // Wavefront qualifiers shared by the FSM and the datapath
  always_comb begin
    stall     = |(due & buf_empty);
    wait_go   = (fill_seen_q | fill_done) && (buf_empty == '0);
    last_rd   = (cyc_q == (CYC_W'(len_q) + CYC_W'(LANES - 2)));
    drain_end = (cyc_q == CYC_W'(PIPE_LAT));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort overrides every non-idle transition
  always_comb begin
    state_d = state_q;
    if (state_q != IDLE && abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:      if (start && burst_len != '0) state_d = WAIT_FILL;
        WAIT_FILL: if (wait_go)                  state_d = STREAM;
        STREAM:    if (!stall && last_rd)        state_d = DRAIN;
        DRAIN:     if (drain_end)                state_d = DONE;
        DONE:                                    state_d = IDLE;
        default:                                 state_d = IDLE;
      endcase
    end
  end

  // State-decoded outputs
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  // Counters and registered outputs; cyc is reused as the drain counter
  always_comb begin
    len_d          = len_q;
    cyc_d          = cyc_q;
    fill_seen_d    = fill_seen_q;
    stall_cycles_d = stall_cycles_q;
    rd_en_d        = '0;
    lane_valid_d   = rd_en_q;
    array_clr_d    = 1'b0;
    len_err_d      = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        if (burst_len == '0) begin
          len_err_d = 1'b1;
        end else begin
          len_d          = burst_len;
          stall_cycles_d = '0;
          fill_seen_d    = fill_done;
        end
      end
    end else begin
      if (fill_done) fill_seen_d = 1'b1;
      if (!abort) begin
        case (state_q)
          WAIT_FILL: begin
            if (wait_go) begin
              cyc_d       = '0;
              array_clr_d = 1'b1;
            end
          end
          STREAM: begin
            if (stall) begin
              if (stall_cycles_q != '1) stall_cycles_d = stall_cycles_q + STALL_W'(1);
            end else begin
              rd_en_d = due;
              cyc_d   = last_rd ? '0 : cyc_q + CYC_W'(1);
            end
          end
          DRAIN:   cyc_d = cyc_q + CYC_W'(1);
          default: ;
        endcase
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q          <= '0;
      cyc_q          <= '0;
      fill_seen_q    <= 1'b0;
      stall_cycles_q <= '0;
      rd_en_q        <= '0;
      lane_valid_q   <= '0;
      array_clr_q    <= 1'b0;
      len_err_q      <= 1'b0;
    end else begin
      len_q          <= len_d;
      cyc_q          <= cyc_d;
      fill_seen_q    <= fill_seen_d;
      stall_cycles_q <= stall_cycles_d;
      rd_en_q        <= rd_en_d;
      lane_valid_q   <= lane_valid_d;
      array_clr_q    <= array_clr_d;
      len_err_q      <= len_err_d;
    end
  end

  assign rd_en        = rd_en_q;
  assign lane_valid   = lane_valid_q;
  assign array_clr    = array_clr_q;
  assign len_err      = len_err_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_systolic_feed_scheduler.sv
// Directed bench for systolic_feed_scheduler: vector table plus corner-case sequences.
module tb_systolic_feed_scheduler;

  localparam int unsigned LANES    = 5;
  localparam int unsigned LEN_W    = 7;
  localparam int unsigned PIPE_LAT = 10;
  localparam int unsigned STALL_W  = 16;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [LEN_W-1:0]   burst_len;
  logic               fill_done;
  logic               abort;
  logic [LANES-1:0]   buf_empty;
  logic [LANES-1:0]   rd_en;
  logic [LANES-1:0]   lane_valid;
  logic               array_clr;
  logic               busy;
  logic               done;
  logic               len_err;
  logic [STALL_W-1:0] stall_cycles;

  systolic_feed_scheduler #(
    .LANES    (LANES),
    .LEN_W    (LEN_W),
    .PIPE_LAT (PIPE_LAT),
    .STALL_W  (STALL_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .burst_len    (burst_len),
    .fill_done    (fill_done),
    .abort        (abort),
    .buf_empty    (buf_empty),
    .rd_en        (rd_en),
    .lane_valid   (lane_valid),
    .array_clr    (array_clr),
    .busy         (busy),
    .done         (done),
    .len_err      (len_err),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             st;
    logic [LEN_W-1:0] len;
    logic             fill;
    logic [4:0]       empty;
    logic [4:0]       x_rd;
    logic [4:0]       x_lv;
    logic             x_clr;
    logic             x_busy;
    logic             x_done;
    logic             x_err;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;
  int   lane_cnt[LANES];
  int   done_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic st, input int len, input logic fill, input logic [4:0] empty,
                     input logic [4:0] x_rd, input logic [4:0] x_lv, input logic x_clr,
                     input logic x_busy, input logic x_done, input logic x_err);
    vec_t v;
    v.st = st; v.len = LEN_W'(len); v.fill = fill; v.empty = empty;
    v.x_rd = x_rd; v.x_lv = x_lv; v.x_clr = x_clr;
    v.x_busy = x_busy; v.x_done = x_done; v.x_err = x_err;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counts();
    for (int i = 0; i < LANES; i++) lane_cnt[i] = 0;
    done_cnt = 0;
  endtask

  task automatic step_count();
    step();
    for (int i = 0; i < LANES; i++) if (rd_en[i]) lane_cnt[i]++;
    if (done) done_cnt++;
  endtask

  task automatic count_until_idle(input string name, input int max);
    int n = 0;
    while (busy && n < max) begin
      step_count();
      n++;
    end
    chk({name, " timeout busy"}, 32'(busy), 32'(0));
  endtask

  task automatic chk_lanes(input string name, input int exp);
    for (int i = 0; i < LANES; i++)
      chk($sformatf("%s lane%0d count", name, i), 32'(lane_cnt[i]), 32'(exp));
    chk({name, " done count"}, 32'(done_cnt), 32'(1));
  endtask

  task automatic idle_inputs();
    start = 1'b0; burst_len = '0; fill_done = 1'b0; abort = 1'b0; buf_empty = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();

    // Basic burst, len=3, then zero-length start
    add(1, 3, 1, 5'b00000, 5'b00000, 5'b00000, 0, 1, 0, 0);
    add(0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 1, 1, 0, 0);
    add(0, 0, 0, 5'b00000, 5'b00001, 5'b00000, 0, 1, 0, 0);
    add(0, 0, 0, 5'b00000, 5'b00011, 5'b00001, 0, 1, 0, 0);
    add(0, 0, 0, 5'b00000, 5'b00111, 5'b00011, 0, 1, 0, 0);
    add(0, 0, 0, 5'b00000, 5'b01110, 5'b00111, 0, 1, 0, 0);
    add(0, 0, 0, 5'b00000, 5'b11100, 5'b01110, 0, 1, 0, 0);
    add(0, 0, 0, 5'b00000, 5'b11000, 5'b11100, 0, 1, 0, 0);
    add(0, 0, 0, 5'b00000, 5'b10000, 5'b11000, 0, 1, 0, 0);
    add(0, 0, 0, 5'b00000, 5'b00000, 5'b10000, 0, 1, 0, 0);
    for (int k = 0; k < 9; k++)
      add(0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 0, 1, 0, 0);
    add(0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 0, 1, 1, 0);
    add(0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 0, 0, 0, 0);
    add(1, 0, 0, 5'b00000, 5'b00000, 5'b00000, 0, 0, 0, 1);
    add(0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 0, 0, 0, 0);

    #12;
    chk("reset rd_en", 32'(rd_en), 32'(0));
    chk("reset lane_valid", 32'(lane_valid), 32'(0));
    chk("reset busy", 32'(busy), 32'(0));
    chk("reset done", 32'(done), 32'(0));
    chk("reset stall_cycles", 32'(stall_cycles), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].st; burst_len = vecs[i].len;
      fill_done = vecs[i].fill; buf_empty = vecs[i].empty;
      step();
      chk($sformatf("vec%0d rd_en", i), 32'(rd_en), 32'(vecs[i].x_rd));
      chk($sformatf("vec%0d lane_valid", i), 32'(lane_valid), 32'(vecs[i].x_lv));
      chk($sformatf("vec%0d array_clr", i), 32'(array_clr), 32'(vecs[i].x_clr));
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].x_busy));
      chk($sformatf("vec%0d done", i), 32'(done), 32'(vecs[i].x_done));
      chk($sformatf("vec%0d len_err", i), 32'(len_err), 32'(vecs[i].x_err));
    end
    idle_inputs();

    // Stall: len=4, lane 2 empty for three cycles from STREAM cycle 3
    clr_counts();
    start = 1'b1; burst_len = 7'd4; fill_done = 1'b1;
    step_count();
    start = 1'b0; fill_done = 1'b0;
    step_count();
    chk("stall clr", 32'(array_clr), 32'(1));
    for (int j = 0; j < 11; j++) begin
      buf_empty = (j >= 3 && j < 6) ? 5'b00100 : 5'b00000;
      step_count();
      if (j >= 3 && j < 6) chk($sformatf("stall j%0d rd_en", j), 32'(rd_en), 32'(0));
      if (j == 6) chk("stall release rd_en", 32'(rd_en), 32'(5'b01111));
      if (j == 10) chk("stall last rd_en", 32'(rd_en), 32'(5'b10000));
    end
    buf_empty = '0;
    chk("stall_cycles", 32'(stall_cycles), 32'(3));
    count_until_idle("stall", 60);
    chk_lanes("stall", 4);

    // Start while busy is ignored
    clr_counts();
    start = 1'b1; burst_len = 7'd2; fill_done = 1'b1;
    step_count();
    burst_len = 7'd5; fill_done = 1'b0;
    step_count();
    start = 1'b0;
    count_until_idle("ignore", 60);
    chk_lanes("ignore", 2);

    // Lane 2 empty for five cycles after start with fill_done in the start cycle
    clr_counts();
    start = 1'b1; burst_len = 7'd2; fill_done = 1'b1; buf_empty = 5'b00100;
    step_count();
    start = 1'b0; fill_done = 1'b0;
    chk("wait0 clr", 32'(array_clr), 32'(0));
    for (int k = 1; k < 5; k++) begin
      step_count();
      chk($sformatf("wait%0d clr", k), 32'(array_clr), 32'(0));
      chk($sformatf("wait%0d busy", k), 32'(busy), 32'(1));
    end
    buf_empty = '0;
    step_count();
    chk("wait enter clr", 32'(array_clr), 32'(1));
    count_until_idle("wait", 60);
    chk_lanes("wait", 2);

    // Abort at STREAM cycle 2, then a normal burst
    start = 1'b1; burst_len = 7'd8; fill_done = 1'b1;
    step();
    start = 1'b0; fill_done = 1'b0;
    step();
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort rd_en", 32'(rd_en), 32'(0));
    chk("abort busy", 32'(busy), 32'(0));
    chk("abort done", 32'(done), 32'(0));
    chk("abort lane_valid tail", 32'(lane_valid), 32'(5'b00011));
    step();
    chk("abort lane_valid after", 32'(lane_valid), 32'(0));
    clr_counts();
    start = 1'b1; burst_len = 7'd2; fill_done = 1'b1;
    step_count();
    start = 1'b0; fill_done = 1'b0;
    count_until_idle("post-abort", 60);
    chk_lanes("post-abort", 2);

    // Reset mid-DRAIN, then fill_done in IDLE must not be remembered
    start = 1'b1; burst_len = 7'd1; fill_done = 1'b1;
    step();
    start = 1'b0; fill_done = 1'b0;
    for (int k = 0; k < 9; k++) step();
    chk("drain busy", 32'(busy), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rd_en", 32'(rd_en), 32'(0));
    chk("async lane_valid", 32'(lane_valid), 32'(0));
    chk("async array_clr", 32'(array_clr), 32'(0));
    chk("async busy", 32'(busy), 32'(0));
    chk("async done", 32'(done), 32'(0));
    chk("async len_err", 32'(len_err), 32'(0));
    chk("async stall_cycles", 32'(stall_cycles), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    fill_done = 1'b1;
    step();
    step();
    chk("idle fill busy", 32'(busy), 32'(0));
    fill_done = 1'b0;
    start = 1'b1; burst_len = 7'd2;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("nofill%0d clr", k), 32'(array_clr), 32'(0));
      chk($sformatf("nofill%0d busy", k), 32'(busy), 32'(1));
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("final abort busy", 32'(busy), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
